// File: rtl/mac_feeder_if.sv
// Input beat stream and result stream between mac_feeder and its producer/consumer.
// slave = mac_feeder side, master = producer/consumer side.
interface mac_feeder_if #(
    parameter int W     = 16,
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [W-1:0]     in_data;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_err;

    modport slave (
        input  in_valid, in_sel, in_data, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_sel, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/mac_feeder.sv
// 64-tap FIR front end for alu_mac: one sample beat -> START, RUN (until done/watchdog), OUT.
// Latency 3 + alu_mac cycles per sample; in_ready held low outside IDLE, result held until res_ready.
module mac_feeder #(
    parameter int N       = 64,
    parameter int W       = 16,
    parameter int ACC_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    mac_feeder_if.slave        s,
    output logic [N*W-1:0]     mac_d,
    output logic [N*W-1:0]     mac_cmem,
    output logic               mac_reset,
    input  logic [ACC_W-1:0]   mac_out,
    input  logic               mac_done,
    output logic               busy
);
    localparam int PTR_W = $clog2(N);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_t;

    state_t             state_q, state_d;
    logic [N*W-1:0]     d_q, d_d;
    logic [N*W-1:0]     cmem_q, cmem_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic               beat;

    // clr has priority over a beat in the same IDLE cycle.
    assign s.in_ready  = reset && (state_q == IDLE) && !clr;
    assign beat        = s.in_valid && s.in_ready;
    assign mac_reset   = !reset || (state_q != RUN);
    assign s.res_valid = (state_q == OUT);
    assign s.res_data  = res_data_q;
    assign s.res_err   = res_err_q;
    assign mac_d       = d_q;
    assign mac_cmem    = cmem_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        cmem_d     = cmem_q;
        ptr_d      = ptr_q;
        wd_d       = wd_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    d_d = '0;
                end else if (beat) begin
                    if (s.in_sel) begin
                        cmem_d[int'(ptr_q)*W +: W] = s.in_data;
                        ptr_d = (ptr_q == PTR_W'(N-1)) ? '0 : ptr_q + 1'b1;
                    end else begin
                        d_d     = {d_q[(N-1)*W-1:0], s.in_data};
                        state_d = START;
                    end
                end
            end
            START: begin
                wd_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                if (mac_done) begin
                    res_data_d = mac_out;
                    res_err_d  = 1'b0;
                    state_d    = OUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                    // This cycle is the TIMEOUT-th RUN cycle without done.
                    if (wd_q == WD_W'(TIMEOUT-1)) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (s.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            d_q        <= '0;
            cmem_q     <= '0;
            ptr_q      <= '0;
            wd_q       <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            cmem_q     <= cmem_d;
            ptr_q      <= ptr_d;
            wd_q       <= wd_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural alu_mac stub and a result scoreboard.
module tb_mac_feeder;
    localparam int N = 64;
    localparam int W = 16;
    localparam int ACC_W = 32;
    localparam int LIMIT = 2000;

    logic               clk = 1'b0;
    logic               reset;
    logic               clr;
    logic [N*W-1:0]     mac_d;
    logic [N*W-1:0]     mac_cmem;
    logic               mac_reset;
    logic [ACC_W-1:0]   mac_out;
    logic               mac_done;
    logic               busy;
    logic               stub_hang;
    int                 stub_cnt;

    int checks = 0;
    int failures = 0;
    logic [ACC_W:0] sb[$];

    mac_feeder_if #(.W(W), .ACC_W(ACC_W)) bus ();

    mac_feeder #(.N(N), .W(W), .ACC_W(ACC_W), .TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .s         (bus),
        .mac_d     (mac_d),
        .mac_cmem  (mac_cmem),
        .mac_reset (mac_reset),
        .mac_out   (mac_out),
        .mac_done  (mac_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] dot(input logic [N*W-1:0] d, input logic [N*W-1:0] c);
        logic signed [ACC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++)
            acc = acc + $signed(d[i*W +: W]) * $signed(c[i*W +: W]);
        return acc;
    endfunction

    // alu_mac stand-in: done 4 cycles after mac_reset drops, unless told to hang.
    always @(posedge clk) begin
        if (mac_reset) begin
            stub_cnt <= 0;
            mac_done <= 1'b0;
            mac_out  <= '0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 3 && !stub_hang) begin
                mac_done <= 1'b1;
                mac_out  <= dot(mac_d, mac_cmem);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every result handshake.
    always begin
        @(negedge clk);
        #1;
        if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {31'd0, bus.res_err, bus.res_data}, 64'hDEAD);
            end else begin
                logic [ACC_W:0] e;
                e = sb.pop_front();
                chk("res_data", 64'(bus.res_data), 64'(e[ACC_W-1:0]));
                chk("res_err", 64'(bus.res_err), 64'(e[ACC_W]));
            end
        end
    end

    task automatic send(input logic sel, input logic [W-1:0] data);
        int n;
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= LIMIT) chk("in_ready_wait", 64'(n), 64'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic push(input logic err, input logic [ACC_W-1:0] data);
        sb.push_back({err, data});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < LIMIT);
        if (n >= LIMIT) chk("idle_wait", 64'(busy), 64'(0));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int run_cycles;
        reset = 1'b0;
        clr = 1'b0;
        stub_hang = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b0;
        bus.in_data = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_mac_reset", 64'(mac_reset), 64'(1));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_mac_d", 64'(|mac_d), 64'(0));
        chk("rst_res_data", 64'(bus.res_data), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // 1: coef 2 everywhere, samples of 1 -> 2k saturating at 128
        for (int i = 0; i < N; i++) send(1'b1, 16'h0002);
        for (int k = 1; k <= 65; k++) begin
            push(1'b0, 32'(2 * ((k > 64) ? 64 : k)));
            send(1'b0, 16'h0001);
        end
        wait_idle();

        // 2: 65th coefficient wraps onto element 0
        for (int i = 0; i < N; i++) send(1'b1, 16'h0001);
        send(1'b1, 16'h0007);
        pulse_clr();
        push(1'b0, 32'd21);
        send(1'b0, 16'h0003);
        wait_idle();

        // 3: all-ones coefficients, samples of -1 -> -k, final -64
        for (int i = 0; i < N; i++) send(1'b1, 16'h0001);
        pulse_clr();
        for (int k = 1; k <= 64; k++) begin
            push(1'b0, 32'(-k));
            send(1'b0, 16'hFFFF);
        end
        wait_idle();

        // 4: backpressure in OUT; d = {-1 x63, 1} -> -62
        bus.res_ready = 1'b0;
        push(1'b0, 32'hFFFF_FFC2);
        send(1'b0, 16'h0001);
        n = 0;
        while (!bus.res_valid && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_valid_wait", 64'(n < LIMIT), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b1;
        bus.in_data = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_res_valid", 64'(bus.res_valid), 64'(1));
            chk("bp_res_data", 64'(bus.res_data), 64'(32'hFFFF_FFC2));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            chk("bp_mac_reset", 64'(mac_reset), 64'(1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_idle", 64'(busy), 64'(0));
        chk("bp_cmem_untouched", 64'(mac_cmem[2*W-1:W]), 64'(1));

        // 5: done never arrives -> TIMEOUT RUN cycles then error result
        stub_hang = 1'b1;
        push(1'b1, 32'd0);
        send(1'b0, 16'h0000);
        run_cycles = 0;
        n = 0;
        while (!bus.res_valid && n < LIMIT) begin
            @(negedge clk);
            #1;
            if (!mac_reset) run_cycles++;
            n++;
        end
        chk("wd_run_cycles", 64'(run_cycles), 64'(255));
        wait_idle();

        // 6: reset in mid-RUN
        send(1'b0, 16'h0005);
        repeat (5) @(negedge clk);
        #1;
        chk("mid_run_state", 64'(mac_reset), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_low_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_low_mac_reset", 64'(mac_reset), 64'(1));
        @(negedge clk);
        #1;
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_mac_d", 64'(|mac_d), 64'(0));
        chk("mr_mac_cmem", 64'(|mac_cmem), 64'(0));
        chk("mr_res_valid", 64'(bus.res_valid), 64'(0));
        chk("mr_mac_reset", 64'(mac_reset), 64'(1));
        reset = 1'b1;
        stub_hang = 1'b0;

        // clr beats a simultaneous sample beat
        push(1'b0, 32'd0);
        send(1'b0, 16'h0005);
        wait_idle();
        chk("pre_clr_d0", 64'(mac_d[W-1:0]), 64'(5));
        @(negedge clk);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        bus.in_data = 16'h0009;
        #1;
        chk("clr_vld_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_mac_d", 64'(|mac_d), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
